// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning HI/LO.
// Shift-add multiply, restoring divide, W cycles each.
module md_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [W-1:0] wdata,
  input  logic         mfhi,
  input  logic         mflo,
  output logic [W-1:0] rdata,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic         stall
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    m_q, m_d;
  logic            div_q, div_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic            z_q, z_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dz_q, dz_d;

  logic            op_ok, op_div, op_sgn;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic            accept;
  logic [W:0]      mul_sum;
  logic [W:0]      div_trial;
  logic [2*W-1:0]  prod_neg;
  logic [W-1:0]    q_mag, r_mag;

  // Operand decode, magnitudes and per-step arithmetic
  always_comb begin
    op_ok     = (op == 4'd3) || (op == 4'd4) ||
                (op == 4'd5) || (op == 4'd6);
    op_div    = (op == 4'd5) || (op == 4'd6);
    op_sgn    = (op == 4'd3) || (op == 4'd5);
    a_neg     = op_sgn & a[W-1];
    b_neg     = op_sgn & b[W-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    accept    = (state_q == IDLE) & start & op_ok;
    mul_sum   = {1'b0, acc_q[2*W-1:W]} +
                (acc_q[0] ? {1'b0, m_q} : '0);
    div_trial = acc_q[2*W-1:W-1] - {1'b0, m_q};
    prod_neg  = -acc_q;
    q_mag     = acc_q[W-1:0];
    r_mag     = acc_q[2*W-1:W];
  end

  // Next-state: FSM sequencing, datapath steps, HI/LO writes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    z_d     = z_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          m_d     = op_div ? b_mag : a_mag;
          acc_d   = {{W{1'b0}}, op_div ? a_mag : b_mag};
          div_d   = op_div;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          z_d     = op_div & (b == '0);
          dz_d    = 1'b0;
          cnt_d   = CW'(W - 1);
          busy_d  = 1'b1;
          state_d = (op_div && b == '0) ? FIX : RUN;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      RUN: begin
        if (div_q) begin
          if (!div_trial[W])
            acc_d = {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
          else
            acc_d = {acc_q[2*W-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (z_q) begin
          hi_d = '1;
          lo_d = '1;
          dz_d = 1'b1;
        end else if (div_q) begin
          lo_d = neg_q ? -q_mag : q_mag;
          hi_d = rneg_q ? -r_mag : r_mag;
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      z_q     <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      z_q     <= z_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  // Outputs: read mux has no bypass of same-cycle writes
  always_comb begin
    rdata = mfhi ? hi_q : lo_q;
    hi    = hi_q;
    lo    = lo_q;
    busy  = busy_q;
    done  = done_q;
    dz    = dz_q;
    stall = busy_q & (start | mfhi | mflo | mthi | mtlo);
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit.
// Directed vectors; monitor checks results on done.
module tb_md_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         mfhi = 1'b0;
  logic         mflo = 1'b0;
  logic [W-1:0] rdata, hi, lo;
  logic         busy, done, dz, stall;

  md_unit #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .mfhi(mfhi), .mflo(mflo), .rdata(rdata), .hi(hi),
    .lo(lo), .busy(busy), .done(done), .dz(dz), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop expected result whenever DUT pulses done
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
        check({e.name, "_dz"}, dz, e.dz);
        check({e.name, "_cyc"}, cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle(output int nb);
    int k;
    nb = 0;
    k = 0;
    while (busy && k < 200) begin
      nb++;
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("busy_timeout", 1, 0);
  endtask

  task automatic issue(input logic [3:0] o,
                       input logic [31:0] aa,
                       input logic [31:0] bb,
                       input logic [31:0] eh,
                       input logic [31:0] el,
                       input logic edz,
                       input int lat,
                       input string nm);
    int nb;
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = aa;
    b = bb;
    sb.push_back('{eh, el, edz, cyc + 1 + lat, nm});
    @(negedge clk);
    start = 1'b0;
    wait_idle(nb);
    check({nm, "_busy_cycles"}, nb, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nb;
    bit ok;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", dz, 0);
    rst_n = 1'b1;

    issue(4'd3, 32'd7, 32'hFFFF_FFFD,
          32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, W + 1, "mult_7_m3");
    issue(4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h0000_0001, 0, W + 1, "multu_max");
    issue(4'd5, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, W + 1, "div_m7_2");
    issue(4'd5, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h0, 32'h8000_0000, 0, W + 1, "div_min_m1");
    issue(4'd6, 32'd5, 32'd0,
          32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, "divu_zero");
    issue(4'd6, 32'd100, 32'd7,
          32'd2, 32'd14, 0, W + 1, "divu_100_7");

    // Idle MTHI/MTLO: read returns old value in the write cycle
    @(negedge clk);
    mthi = 1'b1;
    mtlo = 1'b1;
    wdata = 32'h1234_5678;
    mfhi = 1'b1;
    #1 check("mfhi_no_bypass", rdata, 32'd2);
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    mfhi = 1'b0;
    mflo = 1'b1;
    #1 check("mtlo_rdata", rdata, 32'h1234_5678);
    check("mthi_hi", hi, 32'h1234_5678);
    mflo = 1'b0;

    // Invalid op code is ignored
    @(negedge clk);
    start = 1'b1;
    op = 4'd7;
    @(negedge clk);
    start = 1'b0;
    check("badop_busy", busy, 0);
    check("badop_hi", hi, 32'h1234_5678);

    // MFHI/MTHI while busy: stall, MTHI dropped
    @(negedge clk);
    start = 1'b1;
    op = 4'd4;
    a = 32'h0001_0000;
    b = 32'h0003_0000;
    mthi = 1'b1;
    mfhi = 1'b1;
    wdata = 32'hDEAD_BEEF;
    sb.push_back('{32'd3, 32'd0, 0, cyc + 2 + W, "mulu_stall"});
    @(negedge clk);
    start = 1'b0;
    ok = 1'b1;
    nb = 0;
    while (busy && nb < 200) begin
      if (!stall) ok = 1'b0;
      @(negedge clk);
      nb++;
    end
    check("stall_all_busy", ok, 1);
    check("stall_busy_cycles", nb, W + 1);
    check("stall_done_rdata", rdata, 32'd3);
    check("stall_done_nostall", stall, 0);
    mthi = 1'b0;
    mfhi = 1'b0;
    @(negedge clk);
    check("mthi_busy_dropped", hi, 32'd3);

    // Reset in the middle of a MULT
    start = 1'b1;
    op = 4'd3;
    a = 32'd9;
    b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd3, 32'd2, 32'd3,
          32'd0, 32'd6, 0, W + 1, "mult_after_rst");

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
